fetch_unit: RTL
===============

# fetch_unit

Parametrised instruction fetch front-end for the next-generation core. It replaces the direct `pc` → instruction-memory → `inst` path with a request/acknowledge interface to instruction memory, a prefetch FIFO, and a valid/ready hand-off to decode. It supports variable-latency memory, decode back-pressure, and branch/jump redirects that flush in-flight and buffered instructions.

## Interface
Parameters:
- `INST_W`, 9, instruction width in bits.
- `PC_W`, 8, PC/address width; addresses wrap modulo 2^PC_W.
- `DEPTH`, 4, prefetch FIFO entries; power of two, ≥2.
- `RESET_PC`, 0, first fetch address after reset.

Ports:
- `clk`  in  1  sole clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  fetch request, registered.
- `imem_addr`  out  PC_W  fetch address, registered.
- `imem_ack`  in  1  memory returns `imem_rdata` this cycle.
- `imem_rdata`  in  INST_W  instruction word; valid only with `imem_ack`.
- `redirect`  in  1  flush and restart fetch at `redirect_pc`.
- `redirect_pc`  in  PC_W  new fetch address.
- `inst_valid`  out  1  `inst`/`inst_pc` hold a valid instruction.
- `inst`  out  INST_W  head instruction.
- `inst_pc`  out  PC_W  address of `inst`.
- `inst_ready`  in  1  decode accepts the head this cycle.

## Operation
- State machine (`fetch_state`):
  - `F_IDLE` (reset state): no request outstanding.
  - `F_WAIT`: request outstanding.
  - `F_DROP`: request outstanding; its response is discarded.
- Register `next_pc` holds the next address to fetch. It resets to `RESET_PC` and increments by 1 on each issued request, wrapping 0xFF→0x00 at PC_W=8.
- Issue rule:
  - In `F_IDLE`, if FIFO occupancy < DEPTH, assert `imem_req` next cycle with `imem_addr = next_pc`, then go to `F_WAIT`.
  - At most one request is outstanding.
  - Space is reserved at issue.
- In `F_WAIT`, `imem_req` and `imem_addr` hold stable until `imem_ack`. On ack:
  - Push {`imem_rdata`, `imem_addr`} into the FIFO.
  - If occupancy after push/pop < DEPTH, issue the next request back-to-back (stay in `F_WAIT`, new address next cycle).
  - Otherwise deassert `imem_req` and go to `F_IDLE`.
- Pop: a FIFO pop occurs when `inst_valid && inst_ready`. Push and pop in the same cycle are both honoured; occupancy is unchanged.
- `redirect` has priority over everything in its cycle:
  - Flush the FIFO; occupancy becomes 0 and `inst_valid` drops next cycle.
  - Set `next_pc = redirect_pc`.
  - Any pop that cycle is void.
  - If a request is outstanding and not acked this cycle, go to `F_DROP`. Keep `imem_req`/`imem_addr` stable until the ack, then discard the data and go to `F_IDLE`.
  - If acked in the redirect cycle, discard the data and go to `F_IDLE`.
  - A new redirect while in `F_DROP` only updates `next_pc`.
- Wait state: a request remains pending indefinitely while `imem_ack` stays low; there is no timeout.
- FIFO pointers are log2(DEPTH) bits and wrap naturally. Occupancy is log2(DEPTH)+1 bits.

## Timing
- Reset values:
  - `imem_req` 0.
  - `imem_addr` RESET_PC.
  - `inst_valid` 0.
  - `inst` 0.
  - `inst_pc` 0.
  - State `F_IDLE`.
  - FIFO empty.
- Reset assertion mid-operation clears all state immediately, including any outstanding request. After release, the first request is asserted on the first rising edge.
- Latency, FIFO empty, ack in the same cycle as request:
  - Without bypass: `inst_valid` rises one cycle after `imem_ack`.
  - With `FETCH_BYPASS_EN`: see Configuration.
- Sustained throughput is 1 instruction/cycle with `imem_ack` tied high and `inst_ready` high.
- Redirect-to-new-request: `imem_req` with `redirect_pc` appears one cycle after redirect when idle. When a request is pending, it appears one cycle after that request's ack.

## Configuration
- `FETCH_BYPASS_EN` defined:
  - When the FIFO is empty and in `F_WAIT`, `imem_ack` drives `inst_valid`/`inst`/`inst_pc` combinationally in the same cycle.
  - If `inst_ready` is also high, the word is consumed without a FIFO write.
  - Bypass is suppressed in `F_DROP` and on redirect cycles.
- Undefined: all instructions pass through the FIFO, and all outputs are registered or FIFO-sourced.

## Structure
- Package `fetch_pkg`:
  - `fetch_state_t` enum (`F_IDLE`, `F_WAIT`, `F_DROP`).
  - Default parameter constants.
  - Packed entry typedef {pc, inst}.
- Sub-module `fetch_fifo`, instantiated once:
  - Parametrised DEPTH/width, with push, pop and flush.
  - Outputs are occupancy, empty, full, and a head entry.
- `fetch_unit` holds the FSM, `next_pc`, the issue logic, and the optional bypass mux.

## Test plan
- Reset with RESET_PC=0, ack=1, ready=1 → `imem_addr` 0,1,2,… on consecutive cycles; `inst_pc` follows 0,1,2,… with `inst` equal to the returned data, one per cycle.
- ready=0, ack=1, DEPTH=4 → exactly 4 acks accepted, then `imem_req`=0. Raising ready then drains in order 0..3 and fetching resumes at address 4.
- Ack delayed 3 cycles → `imem_req`/`imem_addr` stable for all 4 cycles; exactly one FIFO entry is written.
- Redirect to 0x40 while the request to 0x05 is pending 2 more cycles → the 0x05 data never appears; `inst_valid`=0 until an instruction with `inst_pc`=0x40 appears. A redirect coincident with an ack also drops that ack's data.
- RESET_PC=0xFE, PC_W=8 → `imem_addr` 0xFE, 0xFF, 0x00, 0x01.
- FIFO empty, ack and ready high in the same cycle → with `FETCH_BYPASS_EN`, `inst_valid`=1 in the ack cycle; without it, `inst_valid`=1 one cycle later.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg -- shared types and default geometry for the instruction fetch
// front-end (fetch_unit and its prefetch FIFO).
//   fetch_state_t : fetch FSM states (idle / request outstanding / dropping)
//   DEF_*         : default parameter values
//   fetch_entry_t : one buffered instruction {pc, inst} at default geometry
package fetch_pkg;

  localparam int DEF_INST_W   = 9;
  localparam int DEF_PC_W     = 8;
  localparam int DEF_DEPTH    = 4;
  localparam int DEF_RESET_PC = 0;

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,  // no request outstanding
    F_WAIT = 2'd1,  // request outstanding, response will be kept
    F_DROP = 2'd2   // request outstanding, response will be discarded
  } fetch_state_t;

  typedef struct packed {
    logic [DEF_PC_W-1:0]   pc;
    logic [DEF_INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo -- prefetch buffer between instruction memory and decode.
// Ports:
//   clk, rst      : clock, asynchronous active-low reset
//   push, wdata   : write one entry (ignored when full unless popping too)
//   pop           : remove the head entry (ignored when empty)
//   flush         : discard all entries; wins over push and pop
//   head          : oldest entry (valid when !empty)
//   count         : occupancy, 0..DEPTH
//   empty, full   : occupancy flags
module fetch_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 17,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // NOTE: the storage is reset along with the pointers so that the head
  // (and therefore inst/inst_pc) reads as zero out of reset; with only a
  // handful of entries this costs little.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch front-end: issues one request at a time
// to instruction memory, buffers responses in a prefetch FIFO and hands
// them to decode with valid/ready. A redirect flushes buffered and
// in-flight instructions and restarts fetch at redirect_pc.
// Optional feature macro: FETCH_BYPASS_EN -- when defined, a response that
// arrives while the FIFO is empty is presented to decode in the same cycle.
// Ports:
//   clk, rst                 : clock, asynchronous active-low reset
//   imem_req, imem_addr      : registered fetch request / address
//   imem_ack, imem_rdata     : memory response strobe and instruction word
//   redirect, redirect_pc    : flush and restart fetch address
//   inst_valid, inst, inst_pc: head instruction offered to decode
//   inst_ready               : decode accepts the head this cycle
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int          INST_W   = DEF_INST_W,
  parameter int          PC_W     = DEF_PC_W,
  parameter int          DEPTH    = DEF_DEPTH,
  parameter int unsigned RESET_PC = DEF_RESET_PC
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [PC_W-1:0]   inst_pc,
  input  logic              inst_ready
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int ENT_W = PC_W + INST_W;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  fetch_state_t    state_q, state_d;
  logic            req_d;
  logic [PC_W-1:0] addr_d;
  logic [PC_W-1:0] next_pc_q, next_pc_d;
  logic            issue;
  logic [PC_W-1:0] issue_pc;

  logic             fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [CNT_W-1:0] fifo_count, occ_after;
  entry_t           fifo_head, push_entry;
  logic             ack_take, bypass, bypass_take;

  // A response is kept only in F_WAIT and only when no redirect kills it.
  assign ack_take = (state_q == F_WAIT) && imem_ack && !redirect;

`ifdef FETCH_BYPASS_EN
  assign bypass = ack_take && fifo_empty;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed word taken by decode never touches the FIFO.
  assign bypass_take = bypass && inst_ready;
  assign fifo_push   = ack_take && !bypass_take;
  assign fifo_pop    = !fifo_empty && inst_ready && !redirect;
  assign occ_after   = fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
  assign push_entry  = '{pc: imem_addr, inst: imem_rdata};

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (redirect),
    .wdata (push_entry),
    .head  (fifo_head),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  always_comb begin
    inst_valid = !fifo_empty;
    inst       = fifo_head.inst;
    inst_pc    = fifo_head.pc;
    if (bypass) begin
      inst_valid = 1'b1;
      inst       = imem_rdata;
      inst_pc    = imem_addr;
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned (which would infer a latch).
  always_comb begin
    state_d   = state_q;
    req_d     = imem_req;
    addr_d    = imem_addr;
    next_pc_d = next_pc_q;
    issue     = 1'b0;
    issue_pc  = next_pc_q;
    unique case (state_q)
      F_IDLE: begin
        // Redirect flushes the FIFO, so there is always room to restart.
        if (redirect) begin
          issue    = 1'b1;
          issue_pc = redirect_pc;
        end else if (!fifo_full) begin
          issue = 1'b1;
        end
      end
      F_WAIT: begin
        if (redirect) begin
          if (imem_ack) begin
            issue    = 1'b1;
            issue_pc = redirect_pc;
          end else begin
            state_d   = F_DROP;
            next_pc_d = redirect_pc;
          end
        end else if (imem_ack) begin
          // Issuing only when the slot is free reserves space for the reply.
          if (occ_after < CNT_W'(DEPTH)) begin
            issue = 1'b1;
          end else begin
            state_d = F_IDLE;
            req_d   = 1'b0;
          end
        end
      end
      F_DROP: begin
        // The FIFO was flushed on entry and nothing is pushed here.
        if (imem_ack) begin
          issue = 1'b1;
          if (redirect) issue_pc = redirect_pc;
        end else if (redirect) begin
          next_pc_d = redirect_pc;
        end
      end
      default: begin
        state_d = F_IDLE;
        req_d   = 1'b0;
      end
    endcase
    if (issue) begin
      state_d   = F_WAIT;
      req_d     = 1'b1;
      addr_d    = issue_pc;
      next_pc_d = issue_pc + PC_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= F_IDLE;
      imem_req  <= 1'b0;
      imem_addr <= PC_W'(RESET_PC);
      next_pc_q <= PC_W'(RESET_PC);
    end else begin
      state_q   <= state_d;
      imem_req  <= req_d;
      imem_addr <= addr_d;
      next_pc_q <= next_pc_d;
    end
  end

endmodule
